ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Arbitrates the single 64-bit data port of the shared RAM helper between the scalar core's load/store unit and the vector unit's 512-bit load/store path. Vector accesses are serialized into eight 64-bit beats on the same port, so the separate vector RAM instance can be removed. Sits in `top` between `rvcpu`/`v_rvcpu` and `RAMHelper`; the index computation (`(addr - PC_START) >> 3`) remains outside this block.

## Interface
- `BEATS`, 8, 64-bit beats per vector access (512/64).
- `MAX_WAIT`, 4, scalar grants allowed while a vector request is pending before the vector request is forced to win.
- `clock`  in  1  system clock, all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `s_req`  in  1  scalar request; held until `s_gnt`.
- `s_we`  in  1  scalar write (1) / read (0).
- `s_addr`  in  64  scalar byte address.
- `s_wdata`, `s_wmask`  in  64 each  scalar write data and bit mask.
- `s_gnt`  out  1  combinational one-cycle accept pulse; request fields are sampled in this cycle.
- `s_ack`  out  1  one-cycle completion pulse.
- `s_rdata`  out  64  read data, valid when `s_ack` is high for a read.
- `v_req`, `v_we`  in  1 each  vector request and write select.
- `v_addr`  in  64  vector base byte address; bits [2:0] are ignored (treated as 0).
- `v_wdata`, `v_wmask`  in  512 each  vector write data and bit mask.
- `v_gnt`, `v_ack`  out  1 each  same semantics as the scalar pair.
- `v_rdata`  out  512  assembled read data, valid when `v_ack` is high for a read.
- `m_r_ena`  out  1  RAM read enable; read data returns combinationally in the same cycle.
- `m_r_addr`  out  64  RAM read address.
- `m_r_data`  in  64  RAM read data.
- `m_w_ena`  out  1  RAM write enable; the write commits on the rising edge.
- `m_w_addr`, `m_w_data`, `m_w_mask`  out  64 each  RAM write address, data and mask.

## Operation
- **States:** `IDLE`, `S_ACC`, `V_BEAT`.
- **Grant in `IDLE`:**
  - If only one request is present, that requester is granted.
  - If both are present, scalar wins unless `wait_cnt == MAX_WAIT`, in which case vector wins.
  - `wait_cnt` increments when scalar wins while `v_req` is high. It clears on every vector grant. It saturates at `MAX_WAIT`.
- **On a grant:**
  - Latch we/addr/wdata/wmask.
  - Scalar grant goes to `S_ACC`. Vector grant goes to `V_BEAT` with `beat=0`.
- **`S_ACC` (1 cycle):**
  - Drive `m_r_ena=!we` or `m_w_ena=we`.
  - Address is the latched address; write data and mask are the latched values.
  - Capture `m_r_data` into `s_rdata` on the edge.
  - Go to `IDLE` and pulse `s_ack`.
- **`V_BEAT` (`BEATS` cycles, beat k = 0..7):**
  - Address is `{base[63:3],3'b0} + 8*k`.
  - Write data and mask are slice `[64k+63:64k]` of the latched data and mask.
  - A write beat whose mask slice is all-zero still consumes its cycle but holds `m_w_ena=0`.
  - Read beat k captures `m_r_data` into `v_rdata[64k+63:64k]`.
  - After k=7, go to `IDLE` and pulse `v_ack`.
- **Bursts are atomic:** no scalar access is interleaved into an active vector burst.
- **Output defaults:** outside an active access, `m_*_ena=0` and the address/data/mask outputs are 0.
- **Held read data:** `s_rdata` and `v_rdata` hold their value until the next read of the same requester completes. Writes do not modify them.
- **Address width:** addresses wrap modulo 2^64. No alignment error is reported.

## Timing
- Grant cycle N; `s_gnt`/`v_gnt` are asserted in N.
- Scalar:
  - RAM access in N+1.
  - `s_ack` and `s_rdata` in N+2.
  - Next grant possible in N+2 (`IDLE`).
- Vector:
  - Beats in N+1..N+8.
  - `v_ack` and full `v_rdata` in N+9.
  - Next grant possible in N+9.
- **Ack and grant in the same cycle:** `IDLE` evaluates requests in the cycle in which `s_ack`/`v_ack` is high, so back-to-back scalar operations run at 1 per 2 cycles.
- **Requests outside `IDLE`** are ignored (no grant). Requesters must hold `req` until they see `gnt`.
- **Reset (asynchronous, any state):**
  - State returns to `IDLE`, `wait_cnt=0`, `beat=0`.
  - All outputs go to 0, including `s_rdata` and `v_rdata`.
  - An in-flight burst is abandoned with no ack. Beats already written stay in RAM.
- **First cycle after reset deassertion:** grants are allowed in this cycle.

## Test plan
- **Scalar read:** preload RAM word at 0x8000_0010 with 0xDEAD_BEEF_0123_4567, scalar read of 0x8000_0010 → `s_gnt` at N, `m_r_ena` with `m_r_addr`=0x8000_0010 at N+1, `s_ack` with `s_rdata`=0xDEAD_BEEF_0123_4567 at N+2.
- **Vector write then read:** vector write to 0x8000_0100 with words 0x11..0x88, mask all-ones → eight writes to 0x8000_0100..0x8000_0138 in N+1..N+8, `v_ack` at N+9. A following vector read returns the same 512 bits.
- **Partial vector mask:** vector write with only mask slices 2 and 5 non-zero → `m_w_ena` high only in N+3 and N+6, `v_ack` still at N+9.
- **Contention and starvation:** `s_req` and `v_req` held continuously → four scalar grants, then a vector grant, then a scalar grant. `wait_cnt` back at 0 after the vector grant.
- **Non-preemption:** scalar request raised at N+3 of a vector burst → no `s_gnt` until N+9, scalar `s_ack` at N+11.
- **Reset mid-burst:** assert `reset` at N+4 of a vector write → all outputs 0 immediately, no `v_ack`, beats 0..2 present in RAM and beats 3..7 unchanged, and a new scalar request is granted in the first cycle after deassertion.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Shares the single 64-bit RAM port between scalar accesses and
// 512-bit vector accesses, which are split into 64-bit beats.
module ram_port_arbiter #(
   parameter int BEATS    = 8,
   parameter int MAX_WAIT = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  s_req,
   input  logic                  s_we,
   input  logic [63:0]           s_addr,
   input  logic [63:0]           s_wdata,
   input  logic [63:0]           s_wmask,
   output logic                  s_gnt,
   output logic                  s_ack,
   output logic [63:0]           s_rdata,
   input  logic                  v_req,
   input  logic                  v_we,
   input  logic [63:0]           v_addr,
   input  logic [64*BEATS-1:0]   v_wdata,
   input  logic [64*BEATS-1:0]   v_wmask,
   output logic                  v_gnt,
   output logic                  v_ack,
   output logic [64*BEATS-1:0]   v_rdata,
   output logic                  m_r_ena,
   output logic [63:0]           m_r_addr,
   input  logic [63:0]           m_r_data,
   output logic                  m_w_ena,
   output logic [63:0]           m_w_addr,
   output logic [63:0]           m_w_data,
   output logic [63:0]           m_w_mask
);

   localparam int BW = $clog2(BEATS);
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int DW = 64 * BEATS;

   typedef enum logic [1:0] {
      IDLE,
      S_ACC,
      V_BEAT
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [BW-1:0]     beat;
   logic [WW-1:0]     wait_cnt;
   logic              lat_we;
   logic [63:0]       lat_addr;
   logic [DW-1:0]     lat_wdata;
   logic [DW-1:0]     lat_wmask;
   logic              s_win;
   logic              v_win;
   logic              last_beat;
   logic [63:0]       beat_addr;
   logic [63:0]       beat_wdata;
   logic [63:0]       beat_wmask;

   assign last_beat  = (beat == BW'(BEATS - 1));
   assign beat_addr  = {lat_addr[63:3], 3'b000}
                     + {{(61 - BW){1'b0}}, beat, 3'b000};
   assign beat_wdata = lat_wdata[{beat, 6'd0} +: 64];
   assign beat_wmask = lat_wmask[{beat, 6'd0} +: 64];

   // Scalar has priority until the vector requester has been passed over
   // MAX_WAIT times.
   always_comb begin
      s_win = 1'b0;
      v_win = 1'b0;
      if (state == IDLE && !reset) begin
         v_win = v_req && (!s_req || wait_cnt == WW'(MAX_WAIT));
         s_win = s_req && !v_win;
      end
   end

   assign s_gnt = s_win;
   assign v_gnt = v_win;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (s_win)      state_nx = S_ACC;
            else if (v_win) state_nx = V_BEAT;
         end
         S_ACC:  state_nx = IDLE;
         V_BEAT: if (last_beat) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         beat      <= '0;
         wait_cnt  <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wmask <= '0;
         s_ack     <= 1'b0;
         v_ack     <= 1'b0;
         s_rdata   <= '0;
         v_rdata   <= '0;
      end else begin
         s_ack <= (state == S_ACC);
         v_ack <= (state == V_BEAT) && last_beat;
         if (s_win) begin
            lat_we    <= s_we;
            lat_addr  <= s_addr;
            lat_wdata <= DW'(s_wdata);
            lat_wmask <= DW'(s_wmask);
         end else if (v_win) begin
            lat_we    <= v_we;
            lat_addr  <= v_addr;
            lat_wdata <= v_wdata;
            lat_wmask <= v_wmask;
         end
         if (v_win)
            wait_cnt <= '0;
         else if (s_win && v_req && wait_cnt != WW'(MAX_WAIT))
            wait_cnt <= wait_cnt + WW'(1);
         if (state == V_BEAT && !last_beat) beat <= beat + BW'(1);
         else                               beat <= '0;
         if (state == S_ACC && !lat_we)
            s_rdata <= m_r_data;
         if (state == V_BEAT && !lat_we)
            v_rdata[{beat, 6'd0} +: 64] <= m_r_data;
      end
   end

   always_comb begin
      m_r_ena  = 1'b0;
      m_r_addr = '0;
      m_w_ena  = 1'b0;
      m_w_addr = '0;
      m_w_data = '0;
      m_w_mask = '0;
      unique case (state)
         S_ACC: begin
            if (lat_we) begin
               m_w_ena  = 1'b1;
               m_w_addr = lat_addr;
               m_w_data = lat_wdata[63:0];
               m_w_mask = lat_wmask[63:0];
            end else begin
               m_r_ena  = 1'b1;
               m_r_addr = lat_addr;
            end
         end
         V_BEAT: begin
            // An all-zero mask slice still occupies its beat slot.
            if (lat_we) begin
               m_w_ena  = |beat_wmask;
               m_w_addr = beat_addr;
               m_w_data = beat_wdata;
               m_w_mask = beat_wmask;
            end else begin
               m_r_ena  = 1'b1;
               m_r_addr = beat_addr;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and random checks of ram_port_arbiter against a word-array
// reference of RAM contents and the arbitration rules.
module tb_ram_port_arbiter;

   logic          clock = 1'b0;
   logic          reset;
   logic          s_req, s_we, s_gnt, s_ack;
   logic [63:0]   s_addr, s_wdata, s_wmask, s_rdata;
   logic          v_req, v_we, v_gnt, v_ack;
   logic [63:0]   v_addr;
   logic [511:0]  v_wdata, v_wmask, v_rdata;
   logic          m_r_ena, m_w_ena;
   logic [63:0]   m_r_addr, m_r_data, m_w_addr, m_w_data, m_w_mask;

   logic [63:0]   mem [1024];
   logic [63:0]   ref_mem [1024];
   logic [63:0]   last_s;
   logic [511:0]  last_v;
   int            checks = 0;
   int            errors = 0;

   always #5 clock = ~clock;

   ram_port_arbiter dut (
      .clock(clock), .reset(reset),
      .s_req(s_req), .s_we(s_we), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_wmask(s_wmask),
      .s_gnt(s_gnt), .s_ack(s_ack), .s_rdata(s_rdata),
      .v_req(v_req), .v_we(v_we), .v_addr(v_addr),
      .v_wdata(v_wdata), .v_wmask(v_wmask),
      .v_gnt(v_gnt), .v_ack(v_ack), .v_rdata(v_rdata),
      .m_r_ena(m_r_ena), .m_r_addr(m_r_addr), .m_r_data(m_r_data),
      .m_w_ena(m_w_ena), .m_w_addr(m_w_addr),
      .m_w_data(m_w_data), .m_w_mask(m_w_mask)
   );

   // RAM helper: combinational read, masked write on the rising edge.
   assign m_r_data = mem[m_r_addr[12:3]];
   always @(posedge clock)
      if (m_w_ena)
         mem[m_w_addr[12:3]] <= (mem[m_w_addr[12:3]] & ~m_w_mask)
                              | (m_w_data & m_w_mask);

   task automatic chk(input string tag, input logic [511:0] obs,
                      input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [511:0] vblock(input logic [63:0] a);
      logic [511:0] r;
      logic [63:0]  ba;
      for (int k = 0; k < 8; k++) begin
         ba = {a[63:3], 3'b000} + 64'(8 * k);
         r[64*k +: 64] = ref_mem[ba[12:3]];
      end
      return r;
   endfunction

   function automatic logic [63:0] word_addr(input int w);
      return 64'h8000_0000 + 64'(w * 8);
   endfunction

   task automatic clear_inputs();
      s_req = 0; s_we = 0; s_addr = 0; s_wdata = 0; s_wmask = 0;
      v_req = 0; v_we = 0; v_addr = 0; v_wdata = 0; v_wmask = 0;
   endtask

   task automatic s_op(input logic we, input logic [63:0] a,
                       input logic [63:0] d, input logic [63:0] m);
      int i;
      i = int'(a[12:3]);
      s_req = 1; s_we = we; s_addr = a; s_wdata = d; s_wmask = m;
      #1 chk("s_gnt", s_gnt, 1'b1);
      tick();
      clear_inputs();
      #1;
      chk("s_r_ena", m_r_ena, !we);
      chk("s_w_ena", m_w_ena, we);
      if (we) begin
         chk("s_w_addr", m_w_addr, a);
         chk("s_w_data", m_w_data, d);
         chk("s_w_mask", m_w_mask, m);
         ref_mem[i] = (ref_mem[i] & ~m) | (d & m);
      end else begin
         chk("s_r_addr", m_r_addr, a);
         last_s = ref_mem[i];
      end
      tick();
      #1;
      chk("s_ack", s_ack, 1'b1);
      chk("s_rdata", s_rdata, last_s);
   endtask

   task automatic v_op(input logic we, input logic [63:0] a,
                       input logic [511:0] d, input logic [511:0] m,
                       input int nb);
      logic [63:0]  ba, sl, sm;
      logic [511:0] exp_v;
      int           i;
      exp_v = '0;
      v_req = 1; v_we = we; v_addr = a; v_wdata = d; v_wmask = m;
      #1 chk("v_gnt", v_gnt, 1'b1);
      for (int k = 0; k < nb; k++) begin
         tick();
         clear_inputs();
         #1;
         ba = {a[63:3], 3'b000} + 64'(8 * k);
         i  = int'(ba[12:3]);
         sl = d[64*k +: 64];
         sm = m[64*k +: 64];
         chk("v_ack_early", v_ack, 1'b0);
         chk("v_r_ena", m_r_ena, !we);
         if (we) begin
            chk("v_w_ena", m_w_ena, |sm);
            if (|sm) begin
               chk("v_w_addr", m_w_addr, ba);
               chk("v_w_data", m_w_data, sl);
               chk("v_w_mask", m_w_mask, sm);
            end
            ref_mem[i] = (ref_mem[i] & ~sm) | (sl & sm);
         end else begin
            chk("v_r_addr", m_r_addr, ba);
            exp_v[64*k +: 64] = ref_mem[i];
         end
      end
      if (nb == 8) begin
         tick();
         #1;
         chk("v_ack", v_ack, 1'b1);
         if (!we) last_v = exp_v;
         chk("v_rdata", v_rdata, last_v);
      end
   endtask

   initial begin
      logic [511:0] wd, wm;
      logic [63:0]  ra, rb, w;
      string        seq;
      int           n, cyc, sel;

      clear_inputs();
      reset  = 1;
      last_s = '0;
      last_v = '0;
      for (int i = 0; i < 1024; i++) begin
         w = {$urandom, $urandom};
         mem[i] = w;
         ref_mem[i] = w;
      end
      mem[2] = 64'hDEAD_BEEF_0123_4567;
      ref_mem[2] = 64'hDEAD_BEEF_0123_4567;

      tick(); tick();
      #1;
      chk("rst_s_gnt", s_gnt, 1'b0);
      chk("rst_v_gnt", v_gnt, 1'b0);
      chk("rst_s_ack", s_ack, 1'b0);
      chk("rst_v_ack", v_ack, 1'b0);
      chk("rst_m_r_ena", m_r_ena, 1'b0);
      chk("rst_m_w_ena", m_w_ena, 1'b0);
      chk("rst_m_r_addr", m_r_addr, 64'h0);
      chk("rst_m_w_addr", m_w_addr, 64'h0);
      chk("rst_s_rdata", s_rdata, 64'h0);
      chk("rst_v_rdata", v_rdata, 512'h0);
      tick();
      reset = 0;

      s_op(0, 64'h8000_0010, 0, 0);
      chk("s_read_const", s_rdata, 64'hDEAD_BEEF_0123_4567);

      for (int k = 0; k < 8; k++) wd[64*k +: 64] = 64'h11 * 64'(k + 1);
      v_op(1, 64'h8000_0100, wd, '1, 8);
      chk("v_hold_after_w", v_rdata, 512'h0);
      v_op(0, 64'h8000_0100, 0, 0, 8);
      chk("v_read_back", v_rdata, wd);

      wm = '0;
      wm[128 +: 64] = '1;
      wm[320 +: 64] = {$urandom, $urandom} | 64'h1;
      v_op(1, 64'h8000_0203, rand512(), wm, 8);
      v_op(0, 64'h8000_0200, 0, 0, 8);

      for (int t = 0; t < 24; t++) begin
         sel = $urandom_range(0, 3);
         ra  = word_addr($urandom_range(0, 1023));
         rb  = word_addr($urandom_range(0, 1016)) | 64'($urandom_range(0, 7));
         if (sel < 2) begin
            s_op(sel[0], ra, {$urandom, $urandom}, {$urandom, $urandom});
         end else begin
            for (int k = 0; k < 8; k++)
               case ($urandom_range(0, 2))
                  0:       wm[64*k +: 64] = '0;
                  1:       wm[64*k +: 64] = '1;
                  default: wm[64*k +: 64] = {$urandom, $urandom};
               endcase
            v_op(sel[0], rb, rand512(), wm, 8);
         end
         if ($urandom_range(0, 1) == 1) tick();
      end
      tick();

      // Both requesters held: four scalar wins, then vector, then scalar.
      ra  = word_addr(40);
      rb  = word_addr(80);
      seq = "";
      n   = 0;
      cyc = 0;
      s_req = 1; s_addr = ra;
      v_req = 1; v_addr = rb;
      while (n < 6 && cyc < 60) begin
         #1;
         if (s_gnt) begin seq = {seq, "S"}; n++; end
         if (v_gnt) begin seq = {seq, "V"}; n++; end
         tick();
         cyc++;
      end
      clear_inputs();
      chk("arb_order", (seq == "SSSSVS"), 1'b1);
      last_s = ref_mem[ra[12:3]];
      last_v = vblock(rb);
      tick();
      #1;
      chk("arb_s_ack", s_ack, 1'b1);
      chk("arb_s_rdata", s_rdata, last_s);
      chk("arb_v_rdata", v_rdata, last_v);
      tick();

      // A scalar request during a burst waits for the burst to finish.
      ra = word_addr(300);
      rb = word_addr(500);
      v_req = 1; v_addr = rb;
      #1 chk("np_v_gnt", v_gnt, 1'b1);
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 1) clear_inputs();
         if (c == 3) begin s_req = 1; s_addr = ra; end
         #1;
         if (c >= 3) chk("np_no_s_gnt", s_gnt, 1'b0);
      end
      tick();
      #1;
      last_v = vblock(rb);
      chk("np_v_ack", v_ack, 1'b1);
      chk("np_v_rdata", v_rdata, last_v);
      chk("np_s_gnt", s_gnt, 1'b1);
      tick();
      clear_inputs();
      tick();
      #1;
      last_s = ref_mem[ra[12:3]];
      chk("np_s_ack", s_ack, 1'b1);
      chk("np_s_rdata", s_rdata, last_s);
      tick();

      // Reset in the fourth beat of a vector write.
      rb = word_addr(700);
      v_op(1, rb, rand512(), '1, 3);
      tick();
      reset = 1;
      s_req = 1; s_addr = rb + 64'h8;
      #1;
      chk("mid_rst_w_ena", m_w_ena, 1'b0);
      chk("mid_rst_w_addr", m_w_addr, 64'h0);
      chk("mid_rst_w_data", m_w_data, 64'h0);
      chk("mid_rst_r_ena", m_r_ena, 1'b0);
      chk("mid_rst_s_gnt", s_gnt, 1'b0);
      chk("mid_rst_v_ack", v_ack, 1'b0);
      chk("mid_rst_s_rdata", s_rdata, 64'h0);
      chk("mid_rst_v_rdata", v_rdata, 512'h0);
      tick();
      #1 chk("mid_rst_v_ack2", v_ack, 1'b0);
      tick();
      reset = 0;
      last_s = '0;
      last_v = '0;
      #1 chk("post_rst_s_gnt", s_gnt, 1'b1);
      tick();
      clear_inputs();
      #1 chk("post_rst_r_addr", m_r_addr, rb + 64'h8);
      tick();
      #1;
      chk("post_rst_v_ack", v_ack, 1'b0);
      chk("post_rst_s_ack", s_ack, 1'b1);
      chk("post_rst_s_rdata", s_rdata, ref_mem[rb[12:3] + 10'd1]);
      v_op(0, rb, 0, 0, 8);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
